// File: rtl/branch_pc_unit_pkg.sv
// ----------------------------------------------------------------------------
// branch_pc_unit_pkg : opcode/funct3 constants and FSM state type
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package branch_pc_unit_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/branch_compare.sv
// ----------------------------------------------------------------------------
// branch_compare : conditional-branch condition evaluation (combinational)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module branch_compare
  import branch_pc_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;  // 010/011 are reserved encodings
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_pc_unit.sv
// ----------------------------------------------------------------------------
// branch_pc_unit : PC register, JAL/JALR/branch resolution, misalignment halt
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step_en,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] link_data,
  output logic            link_we,
  output logic            branch_taken,
  output logic            halted,
  output logic            misaligned_trap,
  output logic [XLEN-1:0] trap_pc
);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_trap;
  logic [XLEN-1:0] r_trap_pc;

  logic [6:0]      w_opcode;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_is_branch;
  logic            w_cond;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic            w_taken;
  logic            w_misaligned;

  assign w_opcode    = instr[6:0];
  assign w_is_jal    = (w_opcode == OP_JAL);
  assign w_is_jalr   = (w_opcode == OP_JALR);
  assign w_is_branch = (w_opcode == OP_BRANCH);

  assign w_imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign w_imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .rs1    (rs1_data),
    .rs2    (rs2_data),
    .funct3 (instr[14:12]),
    .taken  (w_cond)
  );

  assign w_pc_plus4 = r_pc + XLEN'(4);

  always_comb begin
    w_target = w_pc_plus4;
    if (w_is_jal)
      w_target = r_pc + w_imm_j;
    else if (w_is_jalr)
      w_target = (rs1_data + w_imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
    else if (w_is_branch)
      w_target = r_pc + w_imm_b;
  end

  assign w_taken      = w_is_jal | w_is_jalr | (w_is_branch & w_cond);
  assign w_misaligned = w_taken & (w_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_trap    <= 1'b0;
      r_trap_pc <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (step_en) begin
            if (w_misaligned) begin
              r_trap_pc <= r_pc;
              r_trap    <= 1'b1;
              r_state   <= ST_HALT;
            end else begin
              r_pc <= w_taken ? w_target : w_pc_plus4;
            end
          end
        end
        ST_HALT: r_state <= ST_HALT;  // only reset leaves HALT
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign pc              = r_pc;
  assign link_data       = w_pc_plus4;
  assign link_we         = (w_is_jal | w_is_jalr) & (r_state == ST_RUN) & step_en & ~w_misaligned;
  assign branch_taken    = w_taken;
  assign halted          = (r_state == ST_HALT);
  assign misaligned_trap = r_trap;
  assign trap_pc         = r_trap_pc;

endmodule

`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_pc_unit : directed stimulus, behavioural PC model, literal pins
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_branch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_en = 1'b0;
  logic        step_en_w = 1'b0;
  logic [31:0] instr = NOP;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;

  wire [31:0] pc, link_data, trap_pc;
  wire        link_we, branch_taken, halted, misaligned_trap;
  wire [31:0] pc_w, link_data_w, trap_pc_w;
  wire        link_we_w, branch_taken_w, halted_w, misaligned_trap_w;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  branch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .step_en(step_en), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .link_data(link_data),
    .link_we(link_we), .branch_taken(branch_taken), .halted(halted),
    .misaligned_trap(misaligned_trap), .trap_pc(trap_pc)
  );

  branch_pc_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .step_en(step_en_w), .instr(NOP),
    .rs1_data(32'h0), .rs2_data(32'h0), .pc(pc_w), .link_data(link_data_w),
    .link_we(link_we_w), .branch_taken(branch_taken_w), .halted(halted_w),
    .misaligned_trap(misaligned_trap_w), .trap_pc(trap_pc_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_is_link(input logic [31:0] ins);
    return (ins[6:0] == 7'h6F) || (ins[6:0] == 7'h67);
  endfunction

  function automatic bit m_taken(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bit lt_s, lt_u;
    lt_u = a < b;
    lt_s = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    if (m_is_link(ins)) return 1'b1;
    if (ins[6:0] != 7'h63) return 1'b0;
    case (ins[14:12])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return lt_s;
      3'd5: return !lt_s;
      3'd6: return lt_u;
      3'd7: return !lt_u;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] p, input logic [31:0] ins, input logic [31:0] a);
    int imm;
    logic [31:0] t;
    if (ins[6:0] == 7'h6F) begin
      imm = (ins[31] ? -(1 << 20) : 0) + (int'(ins[19:12]) << 12) + (int'(ins[20]) << 11)
            + (int'(ins[30:21]) << 1);
      return p + 32'(imm);
    end
    if (ins[6:0] == 7'h67) begin
      imm = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
      t = a + 32'(imm);
      return t - 32'(t % 2);
    end
    imm = (ins[31] ? -4096 : 0) + (int'(ins[7]) << 11) + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1);
    return p + 32'(imm);
  endfunction

  logic [31:0] m_pc, m_tpc;
  logic        m_halt, m_trap;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 32'h0; m_halt <= 1'b0; m_trap <= 1'b0; m_tpc <= 32'h0;
    end else if (!m_halt && step_en) begin
      if (m_taken(instr, rs1_data, rs2_data) && (m_target(m_pc, instr, rs1_data) % 4 != 0)) begin
        m_halt <= 1'b1; m_trap <= 1'b1; m_tpc <= m_pc;
      end else if (m_taken(instr, rs1_data, rs2_data)) begin
        m_pc <= m_target(m_pc, instr, rs1_data);
      end else begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  // Compare every cycle the unit is out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      bit tk, bad;
      tk  = m_taken(instr, rs1_data, rs2_data);
      bad = tk && (m_target(m_pc, instr, rs1_data) % 4 != 0);
      chk("pc",           pc,               m_pc);
      chk("link_data",    link_data,        m_pc + 32'd4);
      chk("link_we",      32'(link_we),     32'(m_is_link(instr) && !m_halt && step_en && !bad));
      chk("branch_taken", 32'(branch_taken), 32'(tk));
      chk("halted",       32'(halted),      32'(m_halt));
      chk("trap",         32'(misaligned_trap), 32'(m_trap));
      chk("trap_pc",      trap_pc,          m_tpc);
    end
  end

  // ---------------- encoders / drivers ----------------
  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic present(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic en);
    @(posedge clk);
    #1;
    instr = ins; rs1_data = a; rs2_data = b; step_en = en;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; step_en = 1'b0; instr = NOP;
    #1;
    chk("rst_pc",     pc,              32'h0);
    chk("rst_halted", 32'(halted),     32'h0);
    chk("rst_trap",   32'(misaligned_trap), 32'h0);
    chk("rst_tpc",    trap_pc,         32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_lwe", 32'(link_we), 32'h0);

    // sequential fetch
    for (int k = 0; k < 5; k++) begin
      present(NOP, 0, 0, 1'b1);
      chk("seq_pc", pc, 32'(4 * k));
      chk("seq_lwe", 32'(link_we), 32'h0);
    end

    // JAL forward/backward
    do_reset();
    present(NOP, 0, 0, 1'b1);
    present(enc_jal(5'd1, 21'd12), 0, 0, 1'b1);
    chk("jal_lwe", 32'(link_we), 32'h1);
    chk("jal_link", link_data, 32'd8);
    present(NOP, 0, 0, 1'b1);
    chk("jal_pc", pc, 32'd16);
    present(enc_jal(5'd2, -21'sd12), 0, 0, 1'b1);
    chk("jalb_link", link_data, 32'd24);
    present(NOP, 0, 0, 1'b1);
    chk("jalb_pc", pc, 32'd8);

    // stall mid-sequence
    for (int k = 0; k < 3; k++) begin
      present(enc_jal(5'd1, 21'd12), 0, 0, 1'b0);
      chk("stall_pc", pc, 32'd12);
      chk("stall_lwe", 32'(link_we), 32'h0);
    end

    // BEQ taken / not taken, reserved funct3
    do_reset();
    present(enc_b(3'b000, 13'd8), 5, 5, 1'b1);
    present(NOP, 0, 0, 1'b1);
    chk("beq_t", pc, 32'd8);
    do_reset();
    present(enc_b(3'b000, 13'd8), 5, 6, 1'b1);
    present(NOP, 0, 0, 1'b1);
    chk("beq_nt", pc, 32'd4);
    present(enc_b(3'b010, 13'd8), 5, 5, 1'b1);
    chk("f3_010", 32'(branch_taken), 32'h0);

    // signed vs unsigned compares
    do_reset();
    present(enc_b(3'b100, 13'd16), 32'hFFFF_FFFF, 1, 1'b1);
    present(NOP, 0, 0, 1'b1);
    chk("blt", pc, 32'd16);
    do_reset();
    present(enc_b(3'b110, 13'd16), 32'hFFFF_FFFF, 1, 1'b1);
    present(NOP, 0, 0, 1'b1);
    chk("bltu", pc, 32'd4);
    do_reset();
    present(enc_b(3'b111, 13'd16), 32'hFFFF_FFFF, 1, 1'b1);
    present(NOP, 0, 0, 1'b1);
    chk("bgeu", pc, 32'd16);

    // JALR, including bit-0 clearing
    do_reset();
    present(NOP, 0, 0, 1'b1);
    present(enc_jalr(5'd1, 5'd1, 12'd3), 32'h101, 0, 1'b1);
    chk("jalr_link", link_data, 32'd8);
    chk("jalr_lwe", 32'(link_we), 32'h1);
    present(enc_jalr(5'd1, 5'd1, 12'd1), 32'h100, 0, 1'b1);
    chk("jalr_pc", pc, 32'h104);
    present(NOP, 0, 0, 1'b1);
    chk("jalr_b0", pc, 32'h100);

    // misaligned JAL traps and halts
    do_reset();
    present(NOP, 0, 0, 1'b1);
    present(NOP, 0, 0, 1'b1);
    present(enc_jal(5'd1, 21'd6), 0, 0, 1'b1);
    chk("trap_lwe", 32'(link_we), 32'h0);
    present(NOP, 0, 0, 1'b1);
    chk("trap_halt", 32'(halted), 32'h1);
    chk("trap_flag", 32'(misaligned_trap), 32'h1);
    chk("trap_tpc", trap_pc, 32'd8);
    present(enc_jal(5'd1, 21'd12), 0, 0, 1'b1);
    chk("halt_pc", pc, 32'd8);
    chk("halt_lwe", 32'(link_we), 32'h0);
    do_reset();

    // wrap from FFFF_FFFC
    chk("wrap_rst", pc_w, 32'hFFFF_FFFC);
    @(posedge clk); #1; step_en_w = 1'b1;
    @(posedge clk); #1; step_en_w = 1'b0;
    @(negedge clk);
    chk("wrap_pc", pc_w, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
